// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants and the default
// baud divisor. Also used by the future uart_rx.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 434;  // 50 MHz / 115200

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Even parity over one data byte.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// CSR-side handshake bundle for the UART transmitter: byte and start pulse in,
// ready and sticky tx_done status out.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 start;
  logic                 ready;
  logic                 tx_done;

  modport master (output data_in, output start, input ready, input tx_done);
  modport slave  (input data_in, input start, output ready, output tx_done);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count. The clear input realigns the bit phase to a frame accept.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running bit counter, wrapping at the terminal count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TC) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == TC);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB first. Define UART_TX_PARITY_EN to build the 8E1
// variant, which inserts an even-parity bit between the data and stop bits.
// All outputs come straight from flops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W        = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus,
  output logic     tx
);

  localparam int                IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_t          state, state_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic [IDX_W-1:0]     bit_idx, idx_nxt;
  logic                 tx_nxt;
  logic                 ready_q, ready_nxt;
  logic                 done_q, done_nxt;
  logic                 accept;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit, par_nxt;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state != IDLE),
    .tick (tick)
  );

  // State and output registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      tx        <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_idx   <= idx_nxt;
      tx        <= tx_nxt;
      ready_q   <= ready_nxt;
      done_q    <= done_nxt;
`ifdef UART_TX_PARITY_EN
      par_bit   <= par_nxt;
`endif
    end
  end

  // Next-state and next-output logic; tx is precomputed so it changes on the bit edge.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    idx_nxt   = bit_idx;
    tx_nxt    = tx;
    ready_nxt = ready_q;
    done_nxt  = done_q;
    accept    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par_bit;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = START;
          shift_nxt = bus.data_in;
          idx_nxt   = '0;
          tx_nxt    = 1'b0;
          ready_nxt = 1'b0;
          done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_nxt   = even_parity(bus.data_in);
`endif
        end
      end
      START: begin
        if (tick) begin
          state_nxt = DATA;
          tx_nxt    = shift_reg[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
            tx_nxt    = par_bit;
`else
            state_nxt = STOP;
            tx_nxt    = 1'b1;
`endif
          end else begin
            shift_nxt = shift_reg >> 1;
            idx_nxt   = bit_idx + IDX_W'(1);
            tx_nxt    = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        ready_nxt = 1'b1;
      end
    endcase
  end

  assign bus.ready   = ready_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx with CLKS_PER_BIT=4. A frame-level model predicts
// ready/tx_done/tx each cycle and queues accepted bytes; a serial monitor decodes
// frames off the tx line and checks them against the queue.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;

  uart_tx_if bus_if();

  uart_tx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         m_busy = 0;
  bit         m_done = 1'b0;
  bit         chk_en = 1'b0;
  bit [10:0]  m_bits = '1;
  int         n_rx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame occupies FRAME_CYC cycles from the accept edge.
  initial begin : model
    logic [7:0] d;
    logic       exp_tx;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 0;
        m_done = 1'b0;
        exp_q.delete();
        chk_en = 1'b1;
      end else if (m_busy == 0) begin
        if (bus_if.start === 1'b1) begin
          d      = bus_if.data_in;
          m_busy = FRAME_CYC;
          m_done = 1'b0;
          m_bits = '1;
          m_bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) m_bits[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
          m_bits[9] = ($countones(d) % 2) == 1;
`endif
          exp_q.push_back(d);
        end
      end else begin
        m_busy--;
        if (m_busy == 0) m_done = 1'b1;
      end
      #1;
      if (chk_en) begin
        exp_tx = (m_busy == 0) ? 1'b1 : m_bits[(FRAME_CYC - m_busy) / C];
        chk("ready", bus_if.ready, (m_busy == 0));
        chk("tx_done", bus_if.tx_done, m_done);
        chk("tx", tx, exp_tx);
      end
    end
  end

  // Serial monitor: detect start bit, sample mid-bit, compare with queued byte.
  initial begin : monitor
    int         cnt;
    bit         active;
    bit [10:0]  rxb;
    logic [7:0] got;
    logic [7:0] exp_b;
    active = 1'b0;
    cnt    = 0;
    rxb    = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst || !chk_en) begin
        active = 1'b0;
      end else begin
        if (!active && tx === 1'b0) begin
          active = 1'b1;
          cnt    = 0;
          rxb    = '0;
        end
        if (active) begin
          if (cnt % C == C / 2) rxb[cnt / C] = tx;
          if (cnt == (NBITS - 1) * C + C / 2) begin
            active = 1'b0;
            n_rx++;
            for (int i = 0; i < 8; i++) got[i] = rxb[1+i];
            if (exp_q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL rx_unexpected_frame: got byte %0h, none expected at %0t", got, $time);
            end else begin
              exp_b = exp_q.pop_front();
              chk("rx_start_bit", rxb[0], 0);
              chk("rx_byte", got, exp_b);
`ifdef UART_TX_PARITY_EN
              chk("rx_parity", rxb[9], $countones(exp_b) % 2);
`endif
              chk("rx_stop_bit", rxb[NBITS-1], 1);
            end
          end
          cnt++;
        end
      end
    end
  end

  // All driver tasks begin and end on a falling edge.
  task automatic idle(input int n);
    repeat (n) begin
      bus_if.data_in = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] d);
    bus_if.start   = 1'b1;
    bus_if.data_in = d;
    @(negedge clk);
    bus_if.start   = 1'b0;
    bus_if.data_in = 8'($urandom);
  endtask

  task automatic pulse_random();
    bus_if.start   = 1'b1;
    bus_if.data_in = 8'($urandom);
    @(negedge clk);
    bus_if.start   = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && m_busy != 0; i++) begin
      bus_if.data_in = 8'($urandom);
      @(negedge clk);
    end
    if (m_busy != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle_timeout: busy %0d cycles left, required 0", m_busy);
    end
  endtask

  task automatic busy_noise();
    for (int i = 0; i < 200 && m_busy != 0; i++) begin
      bus_if.start   = ($urandom_range(0, 11) == 0);
      bus_if.data_in = 8'($urandom);
      @(negedge clk);
    end
    bus_if.start = 1'b0;
  endtask

  initial begin : driver
    int rx0;
    bus_if.start   = 1'b0;
    bus_if.data_in = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // idle after reset
    idle(20);

    // single 0xA5 frame
    rx0 = n_rx;
    send(8'hA5);
    wait_idle();
    idle(3);
    chk("a5_frame_count", n_rx - rx0, 1);

    // starts while busy are ignored
    rx0 = n_rx;
    send(8'h3C);
    idle(3);
    pulse_random();
    idle(14);
    pulse_random();
    wait_idle();
    idle(3);
    chk("busy_start_frame_count", n_rx - rx0, 1);

    // back-to-back frames on the first idle cycle
    rx0 = n_rx;
    send(8'h00);
    wait_idle();
    send(8'hFF);
    wait_idle();
    idle(3);
    chk("b2b_frame_count", n_rx - rx0, 2);

    // reset mid-frame, then a clean frame
    rx0 = n_rx;
    send(8'h55);
    idle(15);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    send(8'h55);
    wait_idle();
    idle(3);
    chk("reset_abort_frame_count", n_rx - rx0, 1);

    // parity-relevant bytes
    send(8'h07);
    wait_idle();
    send(8'hA5);
    wait_idle();
    idle(2);

    // random frames with noise starts during busy
    for (int f = 0; f < 40; f++) begin
      send(8'($urandom));
      busy_noise();
      idle($urandom_range(0, 3));
    end
    wait_idle();
    idle(10);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
